sumador_pipe: RTL
=================

SUMADOR_PIPE -- requirements
Module: sumador_pipe

Interface
REQ-001 Parameter WIDTH, default 32, meaning operand/result width in bits; SHALL be a multiple of 4 and at least 4.
REQ-002 Derived constant ETAPAS = WIDTH/4, meaning the number of 4-bit pipeline stages and the latency in cycles.
REQ-003 CLK  input  1  sole clock; all state SHALL change on the rising edge.
REQ-004 RST  input  1  reset, asynchronous and active-high.
REQ-005 ENB  input  1  pipeline advance enable; 0 stalls every register.
REQ-006 MODO  input  2  operation: 00 add, 01 subtract, 10 hold, 11 clear.
REQ-007 VALID_IN  input  1  A/B/RCI/MODO carry a new operation this cycle.
REQ-008 A, B  input  WIDTH each  operands, unsigned.
REQ-009 RCI  input  1  carry-in (add) or borrow-in (subtract).
REQ-010 Q  output  WIDTH  registered result.
REQ-011 RCO  output  1  registered carry-out (add) or borrow-out (subtract).
REQ-012 VALID_OUT  output  1  Q/RCO hold a newly completed result this cycle.

Function
REQ-013 Add SHALL produce {RCO,Q} = A + B + RCI, modulo 2^(WIDTH+1).
REQ-014 Subtract SHALL produce Q = (A - B - RCI) mod 2^WIDTH, with RCO = 1 exactly when A < B + RCI; internally computed as A + ~B + !RCI, with RCO = !carry.
REQ-015 Stage k (0..ETAPAS-1) SHALL compute bits [4k+3:4k] using the registered carry from stage k-1; stage 0 uses the effective carry-in.
REQ-016 Upper operand slices SHALL be delayed, and completed lower result slices shifted along, so every slice of one operation emerges aligned.
REQ-017 Latency: an operation accepted at edge n (ENB=1, VALID_IN=1, MODO 00/01) SHALL appear on Q/RCO with VALID_OUT=1 after edge n+ETAPAS-1 (visible in the cycle after ETAPAS enabled edges).
REQ-018 Throughput SHALL be one operation per enabled cycle; back-to-back operations of mixed mode SHALL not interfere.
REQ-019 Each stage SHALL carry its own valid and mode bit; the mode SHALL travel with the operation.
REQ-020 VALID_IN=0 with MODO 00/01 SHALL inject a bubble; on a bubble reaching the output, VALID_OUT=0 and Q/RCO SHALL keep their previous values.
REQ-021 MODO=10 (hold) SHALL inject a bubble regardless of VALID_IN; in-flight operations continue.
REQ-022 MODO=11 (clear) with ENB=1 SHALL, at that edge, zero Q, RCO, VALID_OUT and all stage valid bits; in-flight operations are discarded.
REQ-023 ENB=0 SHALL freeze all registers, including Q, RCO and VALID_OUT, and SHALL ignore MODO (clear included) and VALID_IN.
REQ-024 A VALID_OUT pulse SHALL last one enabled cycle per result; during a stall it SHALL remain at its frozen value.

Reset
REQ-025 RST=1 SHALL immediately clear Q=0, RCO=0, VALID_OUT=0 and all pipeline data, carry and valid registers, independent of CLK and ENB.
REQ-026 Operations in flight at reset SHALL be lost; the first operation accepted after RST deasserts SHALL follow REQ-017 exactly.

Structure
REQ-027 Mode encodings (MODO_SUMA, MODO_RESTA, MODO_MANTENER, MODO_LIMPIAR) and the slice width 4 SHALL live in a shared package/include file used by RTL and bench.
REQ-028 One sub-module, sumador_etapa, SHALL implement a registered 4-bit slice (inputs a, b, carry, valid, mode; outputs sum, carry, valid, mode) instantiated ETAPAS times via generate.
REQ-029 The bench SHALL use a separate probador driving all inputs and observing all outputs through wires, with a self-checking reference model.

Verification (WIDTH=32, ETAPAS=8)
REQ-030 Add A=FFFFFFFF, B=00000001, RCI=0 -> 8 enabled edges later Q=00000000, RCO=1, VALID_OUT=1 for one cycle.
REQ-031 Subtract A=00000000, B=00000001, RCI=0 -> Q=FFFFFFFF, RCO=1; subtract A=5, B=3, RCI=1 -> Q=1, RCO=0.
REQ-032 Eight consecutive adds i+i (i=1..8) -> Q=2,4,...,16 on eight consecutive cycles, VALID_OUT held high.
REQ-033 ENB=0 for 3 cycles mid-flight -> results delayed exactly 3 cycles, values unchanged, Q frozen during the stall.
REQ-034 MODO=11 issued 4 cycles after an add -> Q=0, VALID_OUT=0 next cycle; that add never appears.
REQ-035 RST pulsed between clock edges mid-flight -> outputs zero immediately; a subsequent add 2+3 -> Q=5 after 8 enabled edges.

Source files
------------

// File: rtl/sumador_pipe_pkg.sv
// Shared definitions for the pipelined adder/subtractor: mode encodings,
// slice width and a small mode-classification helper.
package sumador_pipe_pkg;

    localparam int unsigned SLICE_W = 4;

    typedef enum logic [1:0] {
        MODO_SUMA     = 2'b00,
        MODO_RESTA    = 2'b01,
        MODO_MANTENER = 2'b10,
        MODO_LIMPIAR  = 2'b11
    } modo_t;

    // True for the modes that carry an arithmetic operation into the pipe.
    function automatic logic es_operacion(input modo_t m);
        return (m == MODO_SUMA) || (m == MODO_RESTA);
    endfunction

endpackage

// File: rtl/sumador_etapa.sv
// One registered 4-bit slice of the pipelined adder/subtractor. The slice
// adds a + b (or a + ~b when resta) + carry_in and registers the result,
// raw carry, valid and mode. Data/carry/mode only load for valid input so a
// bubble leaves the previous result in place; valid always advances.
module sumador_etapa
    import sumador_pipe_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               enb,
    input  logic               clr,
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               carry_in,
    input  logic               valid_in,
    input  logic               mode_in,
    output logic [SLICE_W-1:0] sum,
    output logic               carry_out,
    output logic               valid_out,
    output logic               mode_out
);

    logic [SLICE_W-1:0] b_eff;
    logic [SLICE_W:0]   total;

    // Slice arithmetic: subtraction inverts b, borrow handling is in carry_in.
    always_comb begin
        b_eff = mode_in ? ~b : b;
        total = {1'b0, a} + {1'b0, b_eff} + {{SLICE_W{1'b0}}, carry_in};
    end

    // Slice register: clear wipes everything, bubbles only move the valid bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum       <= '0;
            carry_out <= 1'b0;
            valid_out <= 1'b0;
            mode_out  <= 1'b0;
        end else if (enb) begin
            if (clr) begin
                sum       <= '0;
                carry_out <= 1'b0;
                valid_out <= 1'b0;
                mode_out  <= 1'b0;
            end else begin
                valid_out <= valid_in;
                if (valid_in) begin
                    sum       <= total[SLICE_W-1:0];
                    carry_out <= total[SLICE_W];
                    mode_out  <= mode_in;
                end
            end
        end
    end

endmodule

// File: rtl/sumador_pipe.sv
// Pipelined WIDTH-bit adder/subtractor built from WIDTH/4 registered 4-bit
// slices. Upper operand slices ride along right-shifted so the next slice is
// always in the low nibble; finished result slices are shifted in from the
// top so the full result lines up at the last stage. WIDTH must be a
// multiple of 4 and at least 4.
module sumador_pipe
    import sumador_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ENB,
    input  logic [1:0]       MODO,
    input  logic             VALID_IN,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             RCI,
    output logic [WIDTH-1:0] Q,
    output logic             RCO,
    output logic             VALID_OUT
);

    localparam int unsigned ETAPAS = WIDTH / SLICE_W;

    modo_t modo;
    logic  limpiar;
    logic  acepta;
    logic  resta0;

    logic [SLICE_W-1:0] a_in    [ETAPAS];
    logic [SLICE_W-1:0] b_in    [ETAPAS];
    logic               c_in    [ETAPAS];
    logic               v_in    [ETAPAS];
    logic               m_in    [ETAPAS];
    logic [SLICE_W-1:0] sum_s   [ETAPAS];
    logic               carry_s [ETAPAS];
    logic               valid_s [ETAPAS];
    logic               resta_s [ETAPAS];

    logic [WIDTH-1:0] pa_src  [ETAPAS];
    logic [WIDTH-1:0] pb_src  [ETAPAS];
    logic [WIDTH-1:0] res_src [ETAPAS];
    logic [WIDTH-1:0] pa      [ETAPAS];
    logic [WIDTH-1:0] pb      [ETAPAS];
    logic [WIDTH-1:0] res     [ETAPAS];

    // Mode decode; hold and clear never inject a valid operation.
    always_comb begin
        modo    = modo_t'(MODO);
        limpiar = (modo == MODO_LIMPIAR);
        resta0  = (modo == MODO_RESTA);
        acepta  = VALID_IN && es_operacion(modo);
    end

    // Stage inputs: stage 0 from the ports, stage k from stage k-1 registers.
    // Subtraction enters as A + ~B + !RCI, so the borrow-in is inverted here.
    always_comb begin
        pa_src[0]  = A;
        pb_src[0]  = B;
        res_src[0] = '0;
        c_in[0]    = RCI ^ resta0;
        v_in[0]    = acepta;
        m_in[0]    = resta0;
        for (int unsigned i = 1; i < ETAPAS; i++) begin
            pa_src[i]  = pa[i-1];
            pb_src[i]  = pb[i-1];
            res_src[i] = (res[i-1] >> SLICE_W)
                       | (WIDTH'(sum_s[i-1]) << (WIDTH - SLICE_W));
            c_in[i]    = carry_s[i-1];
            v_in[i]    = valid_s[i-1];
            m_in[i]    = resta_s[i-1];
        end
        for (int unsigned i = 0; i < ETAPAS; i++) begin
            a_in[i] = pa_src[i][SLICE_W-1:0];
            b_in[i] = pb_src[i][SLICE_W-1:0];
        end
    end

    // Operand delay and result alignment registers, loaded with their stage.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int unsigned i = 0; i < ETAPAS; i++) begin
                pa[i]  <= '0;
                pb[i]  <= '0;
                res[i] <= '0;
            end
        end else if (ENB) begin
            for (int unsigned i = 0; i < ETAPAS; i++) begin
                if (limpiar) begin
                    pa[i]  <= '0;
                    pb[i]  <= '0;
                    res[i] <= '0;
                end else if (v_in[i]) begin
                    pa[i]  <= pa_src[i] >> SLICE_W;
                    pb[i]  <= pb_src[i] >> SLICE_W;
                    res[i] <= res_src[i];
                end
            end
        end
    end

    for (genvar k = 0; k < ETAPAS; k++) begin : g_etapa
        sumador_etapa u_etapa (
            .clk       (CLK),
            .rst       (RST),
            .enb       (ENB),
            .clr       (limpiar),
            .a         (a_in[k]),
            .b         (b_in[k]),
            .carry_in  (c_in[k]),
            .valid_in  (v_in[k]),
            .mode_in   (m_in[k]),
            .sum       (sum_s[k]),
            .carry_out (carry_s[k]),
            .valid_out (valid_s[k]),
            .mode_out  (resta_s[k])
        );
    end

    // Outputs come straight from the last stage; borrow-out is the inverted carry.
    always_comb begin
        Q = (res[ETAPAS-1] >> SLICE_W)
          | (WIDTH'(sum_s[ETAPAS-1]) << (WIDTH - SLICE_W));
        RCO       = carry_s[ETAPAS-1] ^ resta_s[ETAPAS-1];
        VALID_OUT = valid_s[ETAPAS-1];
    end

endmodule
